// File: rtl/dma_pkg.sv
// dma_pkg: shared types and helpers for the DMA channel arbiter.
package dma_pkg;
    localparam int NUM_CH_DEFAULT = 4;
    typedef logic [$clog2(NUM_CH_DEFAULT)-1:0] chIndex_t;
    typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} arbState_e;
    function automatic logic [NUM_CH_DEFAULT-1:0] rotl(input logic [NUM_CH_DEFAULT-1:0] v, input chIndex_t n);
        return (v << n) | (v >> (NUM_CH_DEFAULT - int'(n)));
    endfunction
endpackage

// File: rtl/dma_rotating_priority_encoder.sv
// dma_rotating_priority_encoder: first set request searching upward from prio_high, wrapping.
module dma_rotating_priority_encoder
    import dma_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEFAULT,
    parameter int CH_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   prio_high,
    output logic [CH_W-1:0]   winner,
    output logic              any_req
);
    logic [CH_W-1:0] idx;
    int              s;
    // walk from lowest to highest priority so the highest-priority hit is written last
    always_comb begin
        winner = '0;
        any_req = 1'b0;
        idx = '0;
        s = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            s = int'(prio_high) + k;
            s = (s >= NUM_CH) ? s - NUM_CH : s;
            idx = CH_W'(s);
            if (req[idx]) begin
                winner = idx;
                any_req = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter: DMA channel arbitration, HRQ/HLDA handshake and DACK drive.
module dma_priority_arbiter
    import dma_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEFAULT,
    parameter int CH_W = $clog2(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [NUM_CH-1:0] DREQ,
    output logic [NUM_CH-1:0] DACK,
    output logic              HRQ,
    input  logic              HLDA,
    input  logic [NUM_CH-1:0] maskReg,
    input  logic [NUM_CH-1:0] requestReg,
    input  logic              dreqSenseLow,
    input  logic              dackSenseHigh,
    input  logic              rotatingPriority,
    input  logic              controllerDisable,
    input  logic              assertDACK,
    input  logic              cycleDone,
    output logic [CH_W-1:0]   grantChannel,
    output logic              grantValid,
    output logic [NUM_CH-1:0] clearRequest
);
    arbState_e         state;
    logic [CH_W-1:0]   prio_high;
    logic [CH_W-1:0]   winner;
    logic              any_req;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] ack_on;

    assign req = controllerDisable ? '0 : ((DREQ ^ {NUM_CH{dreqSenseLow}}) | requestReg) & ~maskReg;

    dma_rotating_priority_encoder #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_enc (
        .req       (req),
        .prio_high (rotatingPriority ? prio_high : '0),
        .winner    (winner),
        .any_req   (any_req)
    );

    assign ack_on = {NUM_CH{grantValid & assertDACK}} & (NUM_CH'(1) << grantChannel);
    assign DACK = dackSenseHigh ? ack_on : ~ack_on;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            HRQ <= 1'b0;
            grantValid <= 1'b0;
            grantChannel <= '0;
            clearRequest <= '0;
            prio_high <= '0;
        end else begin
            clearRequest <= '0;
            case (state)
                IDLE: if (any_req) begin
                    state <= REQ;
                    HRQ <= 1'b1;
                end
                REQ: if (HLDA) begin
                    grantChannel <= winner;
                    grantValid <= 1'b1;
                    state <= GRANT;
                end else if (!any_req) begin
                    state <= IDLE;
                    HRQ <= 1'b0;
                end
                // completion wins over a simultaneous HLDA drop
                GRANT: if (cycleDone) begin
                    clearRequest <= NUM_CH'(1) << grantChannel;
                    if (rotatingPriority)
                        prio_high <= (grantChannel == CH_W'(NUM_CH - 1)) ? '0 : grantChannel + 1'b1;
                    grantValid <= 1'b0;
                    HRQ <= 1'b0;
                    state <= RELEASE;
                end else if (!HLDA) begin
                    grantValid <= 1'b0;
                    HRQ <= 1'b0;
                    state <= IDLE;
                end
                default: if (!HLDA) state <= IDLE;
            endcase
        end
    end

    a_one_dack: assert property (@(posedge CLK) disable iff (!RESET_N) $onehot0(ack_on));
    a_gv_hrq: assert property (@(posedge CLK) disable iff (!RESET_N) grantValid |-> HRQ);
    a_clr_onehot: assert property (@(posedge CLK) disable iff (!RESET_N) $onehot0(clearRequest));
    a_rel_hrq: assert property (@(posedge CLK) disable iff (!RESET_N) (state == RELEASE) |-> !HRQ);
endmodule

// File: tb/tb_dma_priority_arbiter.sv
// tb_dma_priority_arbiter: directed vector table plus hand sequences for dma_priority_arbiter.
module tb_dma_priority_arbiter;
    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [3:0] DREQ = '0;
    logic [3:0] DACK;
    logic       HRQ;
    logic       HLDA = 1'b0;
    logic [3:0] maskReg = '0;
    logic [3:0] requestReg = '0;
    logic       dreqSenseLow = 1'b0;
    logic       dackSenseHigh = 1'b0;
    logic       rotatingPriority = 1'b0;
    logic       controllerDisable = 1'b0;
    logic       assertDACK = 1'b0;
    logic       cycleDone = 1'b0;
    logic [1:0] grantChannel;
    logic       grantValid;
    logic [3:0] clearRequest;

    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] dreq;
        logic [3:0] mask;
        logic [3:0] rq;
        logic       sl;
        logic       dis;
        logic       dh;
        logic       hrq;
        logic [1:0] grant;
    } vec_t;

    vec_t vecs[8];

    dma_priority_arbiter dut (
        .CLK               (CLK),
        .RESET_N           (RESET_N),
        .DREQ              (DREQ),
        .DACK              (DACK),
        .HRQ               (HRQ),
        .HLDA              (HLDA),
        .maskReg           (maskReg),
        .requestReg        (requestReg),
        .dreqSenseLow      (dreqSenseLow),
        .dackSenseHigh     (dackSenseHigh),
        .rotatingPriority  (rotatingPriority),
        .controllerDisable (controllerDisable),
        .assertDACK        (assertDACK),
        .cycleDone         (cycleDone),
        .grantChannel      (grantChannel),
        .grantValid        (grantValid),
        .clearRequest      (clearRequest)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input logic [3:0] d, input logic [3:0] m, input logic [3:0] r,
                          input logic sl, input logic dis, input logic rot, input logic dh);
        DREQ = d;
        maskReg = m;
        requestReg = r;
        dreqSenseLow = sl;
        controllerDisable = dis;
        rotatingPriority = rot;
        dackSenseHigh = dh;
    endtask

    task automatic go_grant(input logic [1:0] exp, input string tag);
        int t = 0;
        logic [3:0] on;
        while (!HRQ && t < 10) begin
            tick();
            t++;
        end
        chk({tag, "_hrq_rise"}, {3'b0, HRQ}, 4'b0001);
        repeat (2) tick();
        HLDA = 1'b1;
        assertDACK = 1'b1;
        tick();
        chk({tag, "_gv"}, {3'b0, grantValid}, 4'b0001);
        chk({tag, "_grant"}, {2'b0, grantChannel}, {2'b0, exp});
        on = 4'b0001 << exp;
        chk({tag, "_dack"}, DACK, dackSenseHigh ? on : ~on);
    endtask

    task automatic finish_xfer(input logic [1:0] exp, input string tag);
        cycleDone = 1'b1;
        tick();
        cycleDone = 1'b0;
        chk({tag, "_clr"}, clearRequest, 4'b0001 << exp);
        chk({tag, "_hrq_fall"}, {3'b0, HRQ}, 4'b0000);
        chk({tag, "_dack_off"}, DACK, dackSenseHigh ? 4'b0000 : 4'b1111);
        HLDA = 1'b0;
        assertDACK = 1'b0;
        controllerDisable = 1'b1;
        tick();
        chk({tag, "_clr_end"}, clearRequest, 4'b0000);
        tick();
    endtask

    initial begin
        vecs[0] = '{4'b1010, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
        vecs[1] = '{4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[2] = '{4'b0001, 4'b0001, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2};
        vecs[3] = '{4'b1110, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0};
        vecs[4] = '{4'b1110, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[5] = '{4'b1100, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3};
        vecs[6] = '{4'b0110, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
        vecs[7] = '{4'b1010, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};

        #12;
        chk("rst_hrq", {3'b0, HRQ}, 4'b0000);
        chk("rst_gv", {3'b0, grantValid}, 4'b0000);
        chk("rst_grant", {2'b0, grantChannel}, 4'b0000);
        chk("rst_clr", clearRequest, 4'b0000);
        chk("rst_dack", DACK, 4'b1111);
        RESET_N = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            set_in(vecs[i].dreq, vecs[i].mask, vecs[i].rq, vecs[i].sl, vecs[i].dis, 1'b0, vecs[i].dh);
            if (vecs[i].hrq) begin
                go_grant(vecs[i].grant, $sformatf("vec%0d", i));
                finish_xfer(vecs[i].grant, $sformatf("vec%0d", i));
            end else begin
                for (int c = 0; c < 4; c++) begin
                    tick();
                    chk($sformatf("vec%0d_no_hrq", i), {3'b0, HRQ}, 4'b0000);
                end
            end
        end

        for (int i = 0; i < 5; i++) begin
            set_in(4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
            go_grant(2'(i), $sformatf("rot%0d", i));
            finish_xfer(2'(i), $sformatf("rot%0d", i));
        end

        set_in(4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        go_grant(2'd1, "lost");
        HLDA = 1'b0;
        tick();
        chk("lost_gv", {3'b0, grantValid}, 4'b0000);
        chk("lost_hrq", {3'b0, HRQ}, 4'b0000);
        chk("lost_clr", clearRequest, 4'b0000);
        assertDACK = 1'b0;
        go_grant(2'd1, "after_lost");
        finish_xfer(2'd1, "after_lost");

        set_in(4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        go_grant(2'd2, "simul");
        cycleDone = 1'b1;
        HLDA = 1'b0;
        tick();
        cycleDone = 1'b0;
        chk("simul_clr", clearRequest, 4'b0100);
        chk("simul_hrq", {3'b0, HRQ}, 4'b0000);
        chk("simul_gv", {3'b0, grantValid}, 4'b0000);
        assertDACK = 1'b0;
        tick();
        chk("simul_clr_end", clearRequest, 4'b0000);
        set_in(4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        go_grant(2'd3, "post_simul");
        finish_xfer(2'd3, "post_simul");

        set_in(4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        go_grant(2'd0, "pre_rst");
        finish_xfer(2'd0, "pre_rst");
        set_in(4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        go_grant(2'd1, "mid_rst");
        #1;
        RESET_N = 1'b0;
        #1;
        chk("async_dack", DACK, 4'b0000);
        chk("async_hrq", {3'b0, HRQ}, 4'b0000);
        chk("async_gv", {3'b0, grantValid}, 4'b0000);
        chk("async_grant", {2'b0, grantChannel}, 4'b0000);
        HLDA = 1'b0;
        assertDACK = 1'b0;
        tick();
        RESET_N = 1'b1;
        go_grant(2'd0, "post_rst");
        finish_xfer(2'd0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
- Channel arbiter and bus-request sequencer for the 4-channel DMA controller.
- Merges hardware DREQ lines and software request bits, applies mask and polarity settings, and selects one channel by fixed or rotating priority.
- Runs the HRQ/HLDA handshake with the CPU.
- Presents the granted channel to timing-and-control and drives the DACK pins while timing-and-control requests it.

Parameters:
- NUM_CH, 4, number of DMA channels.
- CH_W, $clog2(NUM_CH), width of a channel index.

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- DREQ  in  NUM_CH  channel request pins, polarity set by dreqSenseLow
- DACK  out  NUM_CH  channel acknowledge pins, polarity set by dackSenseHigh
- HRQ  out  1  hold request to CPU
- HLDA  in  1  hold acknowledge from CPU
- maskReg  in  NUM_CH  1 = channel masked
- requestReg  in  NUM_CH  software request bits
- dreqSenseLow  in  1  1 = DREQ active-low
- dackSenseHigh  in  1  1 = DACK active-high
- rotatingPriority  in  1  1 = rotating, 0 = fixed (ch0 highest)
- controllerDisable  in  1  1 = ignore all requests
- assertDACK  in  1  from timing-and-control: drive DACK of granted channel
- cycleDone  in  1  one-cycle pulse from timing-and-control at end of transfer (S4)
- grantChannel  out  CH_W  latched winning channel
- grantValid  out  1  grantChannel is valid
- clearRequest  out  NUM_CH  one-cycle pulse that clears the serviced software request bit

Behaviour:
- Effective request:
  - req[i] = ((DREQ[i] ^ dreqSenseLow) | requestReg[i]) & ~maskReg[i].
  - req = 0 when controllerDisable = 1.
- Priority pointer prioHigh (CH_W bits):
  - Reset value 0.
  - Winner = first set req bit searching upward from prioHigh, wrapping modulo NUM_CH.
  - In fixed mode the search always starts at 0.
- FSM with states IDLE, REQ, GRANT, RELEASE:
  - IDLE: HRQ = 0. Go to REQ when |req = 1.
  - REQ: HRQ = 1.
    - HLDA = 1: latch winner into grantChannel, set grantValid, go to GRANT.
    - HLDA = 0 and req = 0: go back to IDLE.
  - GRANT: HRQ = 1; grant is frozen, and later req changes are ignored.
    - cycleDone = 1:
      - pulse clearRequest[grantChannel] for one cycle;
      - if rotatingPriority, prioHigh <= grantChannel + 1 (mod NUM_CH), so the serviced channel becomes lowest priority;
      - clear grantValid and go to RELEASE.
    - HLDA = 0 without cycleDone (bus lost): clear grantValid and go to IDLE. No rotation, no clearRequest.
  - RELEASE: HRQ = 0. Stay at least one cycle, then go to IDLE once HLDA = 0.
- HRQ, grantChannel, grantValid and clearRequest are registered, so HRQ rises one cycle after the edge that first samples |req.
- DACK is combinational:
  - DACK[i] is active only when grantValid = 1, assertDACK = 1 and grantChannel = i.
  - Active level = dackSenseHigh; inactive level = ~dackSenseHigh.
- Simultaneous events:
  - cycleDone together with HLDA falling counts as a completion: rotate, pulse clearRequest, go to RELEASE, then IDLE on the next edge.
  - A mode or mask change during GRANT takes effect at the next arbitration.
- Reset (asynchronous, any state):
  - state = IDLE, HRQ = 0, grantValid = 0, grantChannel = 0, clearRequest = 0, prioHigh = 0.
  - DACK goes inactive immediately.
- Assertions:
  - At most one DACK active.
  - grantValid implies HRQ.
  - clearRequest is one-hot or zero.
  - HRQ never rises while in RELEASE.

Decomposition:
- Shared package dma_pkg holds:
  - NUM_CH_DEFAULT;
  - chIndex_t;
  - arbState_e (IDLE, REQ, GRANT, RELEASE);
  - helper function rotl for the request vector.
- One sub-module, dma_rotating_priority_encoder:
  - inputs req and prioHigh;
  - outputs winner index and anyReq;
  - purely combinational; the FSM stays in dma_priority_arbiter.

Test Plan:
- Fixed mode, DREQ = 4'b1010, HLDA asserted 2 cycles after HRQ -> grantChannel = 1; with assertDACK = 1 and dackSenseHigh = 0, DACK = 4'b1101; cycleDone -> HRQ falls, next winner is 1 again.
- Rotating mode, DREQ = 4'b1111 held, four transfers -> grants in order 0, 1, 2, 3, and prioHigh wraps back to 0.
- maskReg = 4'b0001, DREQ = 4'b0001 -> HRQ stays 0; requestReg = 4'b0100 -> grant 2, and clearRequest = 4'b0100 pulses on cycleDone.
- dreqSenseLow = 1, DREQ = 4'b1110 -> channel 0 requests and is granted; controllerDisable = 1 -> no HRQ.
- HLDA drops during GRANT with no cycleDone -> grantValid = 0 and IDLE; prioHigh and clearRequest unchanged.
- RESET_N pulled low mid-GRANT with assertDACK = 1 -> DACK goes inactive and HRQ = 0 with no clock edge.
